// File: rtl/mlp_sequencer.sv
// mlp_sequencer -- evaluates an N-input, H-hidden-neuron, single-output MLP
// with signed Q16.16 arithmetic, fetching one weight per cycle from an
// external synchronous ROM.
//
// Ports:
//   ADC_CLK_10  clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle evaluation request (accepted only in IDLE)
//   abort       synchronous cancel of a running evaluation
//   entradas    N flattened 32-bit Q16.16 inputs, entry i at [32*i +: 32]
//   w_addr      weight ROM address (0 when not issuing)
//   w_data      weight ROM data, valid one cycle after w_addr
//   busy        high while an evaluation is running
//   done        one-cycle pulse when score/resultado are updated
//   score       output neuron value before thresholding, Q16.16
//   resultado   1 when score is strictly positive
module mlp_sequencer #(
  parameter int N               = 6,
  parameter int H               = 4,
  parameter int QtdBitsDecimais = 16
) (
  input  logic            ADC_CLK_10,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [32*N-1:0] entradas,
  output logic [7:0]      w_addr,
  input  logic [31:0]     w_data,
  output logic            busy,
  output logic            done,
  output logic [31:0]     score,
  output logic            resultado
);

  localparam int NW = $clog2(N);
  localparam int HW = $clog2(H);
  localparam logic [7:0] K_LAST_HID = 8'(N);
  localparam logic [7:0] K_LAST_OUT = 8'(H);
  localparam logic [7:0] H_LAST     = 8'(H - 1);
  localparam logic [7:0] OUT_BASE   = 8'(H * (N + 1));

  typedef enum logic [2:0] {IDLE, HID_MAC, HID_ACT, OUT_MAC, OUT_FIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  h_reg, h_next, k_reg, k_next;
  logic [31:0] acc_reg, acc_next;
  logic        pend_reg, pend_next;   // a ROM word arrives this cycle
  logic        bias_reg, bias_next;   // that word is a bias (added unscaled)
  logic [31:0] op_reg, op_next;       // operand paired with the arriving word
  logic [31:0] score_reg, score_next;
  logic        res_reg, res_next;
  logic        load_in, hid_we, clear_hid;

  logic [31:0] entradas_arr [N];
  logic [31:0] in_reg       [N];
  logic [31:0] hidden_reg   [H];

  logic [31:0] prod_term, term, acc_sum, relu;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign entradas_arr[gi] = entradas[32*gi +: 32];
    end
  endgenerate

  // Full 64-bit signed product, rescaled back to Q16.16 and truncated.
  assign prod_term = 32'(($signed({{32{op_reg[31]}}, op_reg}) *
                          $signed({{32{w_data[31]}}, w_data})) >>> QtdBitsDecimais);
  assign term      = bias_reg ? w_data : prod_term;
  // The last word of each MAC sweep lands in the ACT/FIN cycle, so the
  // activation and the score both see the accumulator including it.
  assign acc_sum   = pend_reg ? acc_reg + term : acc_reg;
  assign relu      = acc_sum[31] ? 32'd0 : acc_sum;

  assign busy      = (state_reg == HID_MAC) || (state_reg == HID_ACT) ||
                     (state_reg == OUT_MAC) || (state_reg == OUT_FIN);
  assign done      = (state_reg == DONE);
  assign score     = score_reg;
  assign resultado = res_reg;

  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    k_next     = k_reg;
    acc_next   = acc_sum;
    pend_next  = 1'b0;
    bias_next  = 1'b0;
    op_next    = '0;
    score_next = score_reg;
    res_next   = res_reg;
    load_in    = 1'b0;
    hid_we     = 1'b0;
    clear_hid  = 1'b0;
    w_addr     = '0;
    case (state_reg)
      IDLE: begin
        acc_next = '0;
        if (start && !abort) begin
          load_in    = 1'b1;
          h_next     = '0;
          k_next     = '0;
          state_next = HID_MAC;
        end
      end
      HID_MAC: begin
        w_addr    = 8'(h_reg * (N + 1)) + k_reg;
        pend_next = 1'b1;
        if (k_reg == K_LAST_HID) begin
          bias_next  = 1'b1;
          k_next     = '0;
          state_next = HID_ACT;
        end else begin
          op_next = in_reg[k_reg[NW-1:0]];
          k_next  = k_reg + 8'd1;
        end
      end
      HID_ACT: begin
        hid_we   = 1'b1;
        acc_next = '0;
        if (h_reg < H_LAST) begin
          h_next     = h_reg + 8'd1;
          state_next = HID_MAC;
        end else begin
          h_next     = '0;
          state_next = OUT_MAC;
        end
      end
      OUT_MAC: begin
        w_addr    = OUT_BASE + k_reg;
        pend_next = 1'b1;
        if (k_reg == K_LAST_OUT) begin
          bias_next  = 1'b1;
          k_next     = '0;
          state_next = OUT_FIN;
        end else begin
          op_next = hidden_reg[k_reg[HW-1:0]];
          k_next  = k_reg + 8'd1;
        end
      end
      OUT_FIN: begin
        score_next = acc_sum;
        res_next   = $signed(acc_sum) > 32'sd0;
        acc_next   = '0;
        state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides whatever the running state wanted; the previous
    // result stays visible.
    if (abort && busy) begin
      state_next = IDLE;
      h_next     = '0;
      k_next     = '0;
      acc_next   = '0;
      pend_next  = 1'b0;
      bias_next  = 1'b0;
      op_next    = '0;
      score_next = score_reg;
      res_next   = res_reg;
      hid_we     = 1'b0;
      clear_hid  = 1'b1;
    end
  end

  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      h_reg     <= '0;
      k_reg     <= '0;
      acc_reg   <= '0;
      pend_reg  <= 1'b0;
      bias_reg  <= 1'b0;
      op_reg    <= '0;
      score_reg <= '0;
      res_reg   <= 1'b0;
      for (int i = 0; i < N; i++) in_reg[i] <= '0;
      for (int i = 0; i < H; i++) hidden_reg[i] <= '0;
    end else begin
      h_reg     <= h_next;
      k_reg     <= k_next;
      acc_reg   <= acc_next;
      pend_reg  <= pend_next;
      bias_reg  <= bias_next;
      op_reg    <= op_next;
      score_reg <= score_next;
      res_reg   <= res_next;
      if (load_in) begin
        for (int i = 0; i < N; i++) in_reg[i] <= entradas_arr[i];
      end
      if (clear_hid) begin
        for (int i = 0; i < H; i++) hidden_reg[i] <= '0;
      end else if (hid_we) begin
        hidden_reg[h_reg[HW-1:0]] <= relu;
      end
    end
  end

endmodule
